// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the EX-stage branch resolution slice.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        BR_IDLE     = 2'd0,
        BR_PENDING  = 2'd1,
        BR_REDIRECT = 2'd2
    } bch_res_state_e;

    localparam logic [31:0] INSTR_LEN_32 = 32'd4;
    localparam logic [31:0] INSTR_LEN_16 = 32'd2;

endpackage

// File: rtl/cv32e40x_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module cv32e40x_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cv32e40x_bch_resolve.sv
// Tracks one statically predicted branch from ID into EX and issues a
// registered PC redirect plus IF/ID flush when the ALU outcome disagrees.
module cv32e40x_bch_resolve
    import cv32e40x_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_bch_valid_i,
    output logic                 id_bch_ready_o,
    input  logic                 id_bch_prediction_i,
    input  logic [31:0]          id_bch_target_i,
    input  logic [31:0]          id_pc_i,
    input  logic                 id_is_compressed_i,
    input  logic                 ex_resolve_valid_i,
    input  logic                 ex_bch_taken_i,
    input  logic                 kill_i,
    output logic                 redirect_valid_o,
    input  logic                 redirect_ready_i,
    output logic [31:0]          redirect_pc_o,
    output logic                 flush_id_o,
    output logic [CNT_WIDTH-1:0] bch_count_o,
    output logic [CNT_WIDTH-1:0] mispredict_count_o
);

    bch_res_state_e state_q, state_d;

    logic        pred_q, pred_d;
    logic [31:0] target_q, target_d;
    logic [31:0] fallthru_q, fallthru_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        capture;
    logic        resolve;
    logic        mispredict;
    logic [31:0] fallthru;

    assign fallthru   = id_pc_i + (id_is_compressed_i ? INSTR_LEN_16 : INSTR_LEN_32);
    assign capture    = (state_q == BR_IDLE) && id_bch_valid_i && !kill_i;
    assign resolve    = (state_q == BR_PENDING) && ex_resolve_valid_i && !kill_i;
    assign mispredict = resolve && (ex_bch_taken_i != pred_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (kill_i) begin
            state_d = BR_IDLE;
        end else begin
            unique case (state_q)
                BR_IDLE: begin
                    if (id_bch_valid_i) state_d = BR_PENDING;
                end
                BR_PENDING: begin
                    if (ex_resolve_valid_i) begin
                        state_d = (ex_bch_taken_i != pred_q) ? BR_REDIRECT : BR_IDLE;
                    end
                end
                BR_REDIRECT: begin
                    if (redirect_ready_i) state_d = BR_IDLE;
                end
                default: state_d = BR_IDLE;
            endcase
        end
    end

    always_comb begin
        id_bch_ready_o   = 1'b0;
        redirect_valid_o = 1'b0;
        flush_id_o       = 1'b0;
        redirect_pc_o    = '0;
        unique case (state_q)
            BR_IDLE: id_bch_ready_o = 1'b1;
            BR_PENDING: ;
            BR_REDIRECT: begin
                redirect_valid_o = 1'b1;
                flush_id_o       = 1'b1;
                redirect_pc_o    = {redirect_pc_q[31:1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        pred_d        = pred_q;
        target_d      = target_q;
        fallthru_d    = fallthru_q;
        redirect_pc_d = redirect_pc_q;
        if (capture) begin
            pred_d     = id_bch_prediction_i;
            target_d   = id_bch_target_i;
            fallthru_d = fallthru;
        end
        // Latched here so redirect_pc_o only ever depends on registered state.
        if (mispredict) begin
            redirect_pc_d = ex_bch_taken_i ? target_q : fallthru_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_q        <= 1'b0;
            target_q      <= '0;
            fallthru_q    <= '0;
            redirect_pc_q <= '0;
        end else begin
            pred_q        <= pred_d;
            target_q      <= target_d;
            fallthru_q    <= fallthru_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    cv32e40x_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_bch_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (resolve),
        .count_o (bch_count_o)
    );

    cv32e40x_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_mispredict_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (mispredict),
        .count_o (mispredict_count_o)
    );

endmodule

// File: tb/tb_cv32e40x_bch_resolve.sv
// Directed bench for cv32e40x_bch_resolve; a 2-bit-counter copy shares stimulus.
module tb_cv32e40x_bch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_bch_valid_i;
    logic        id_bch_prediction_i;
    logic [31:0] id_bch_target_i;
    logic [31:0] id_pc_i;
    logic        id_is_compressed_i;
    logic        ex_resolve_valid_i;
    logic        ex_bch_taken_i;
    logic        kill_i;
    logic        redirect_ready_i;

    logic        ready_a, valid_a, flush_a;
    logic [31:0] pc_a;
    logic [15:0] bch_a, mis_a;
    logic        ready_b, valid_b, flush_b;
    logic [31:0] pc_b;
    logic [1:0]  bch_b, mis_b;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    cv32e40x_bch_resolve #(.CNT_WIDTH(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .id_bch_valid_i      (id_bch_valid_i),
        .id_bch_ready_o      (ready_a),
        .id_bch_prediction_i (id_bch_prediction_i),
        .id_bch_target_i     (id_bch_target_i),
        .id_pc_i             (id_pc_i),
        .id_is_compressed_i  (id_is_compressed_i),
        .ex_resolve_valid_i  (ex_resolve_valid_i),
        .ex_bch_taken_i      (ex_bch_taken_i),
        .kill_i              (kill_i),
        .redirect_valid_o    (valid_a),
        .redirect_ready_i    (redirect_ready_i),
        .redirect_pc_o       (pc_a),
        .flush_id_o          (flush_a),
        .bch_count_o         (bch_a),
        .mispredict_count_o  (mis_a)
    );

    cv32e40x_bch_resolve #(.CNT_WIDTH(2)) dut_w2 (
        .clk                 (clk),
        .rst                 (rst),
        .id_bch_valid_i      (id_bch_valid_i),
        .id_bch_ready_o      (ready_b),
        .id_bch_prediction_i (id_bch_prediction_i),
        .id_bch_target_i     (id_bch_target_i),
        .id_pc_i             (id_pc_i),
        .id_is_compressed_i  (id_is_compressed_i),
        .ex_resolve_valid_i  (ex_resolve_valid_i),
        .ex_bch_taken_i      (ex_bch_taken_i),
        .kill_i              (kill_i),
        .redirect_valid_o    (valid_b),
        .redirect_ready_i    (redirect_ready_i),
        .redirect_pc_o       (pc_b),
        .flush_id_o          (flush_b),
        .bch_count_o         (bch_b),
        .mispredict_count_o  (mis_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the hand-off.
    task automatic send_bch(input logic pred, input logic [31:0] pc,
                            input logic [31:0] tgt, input logic comp);
        id_bch_valid_i      = 1'b1;
        id_bch_prediction_i = pred;
        id_pc_i             = pc;
        id_bch_target_i     = tgt;
        id_is_compressed_i  = comp;
        @(negedge clk);
        id_bch_valid_i      = 1'b0;
    endtask

    task automatic resolve(input logic taken, input logic kill);
        ex_resolve_valid_i = 1'b1;
        ex_bch_taken_i     = taken;
        kill_i             = kill;
        @(negedge clk);
        ex_resolve_valid_i = 1'b0;
        ex_bch_taken_i     = 1'b0;
        kill_i             = 1'b0;
    endtask

    task automatic accept_redirect();
        redirect_ready_i = 1'b1;
        @(negedge clk);
        redirect_ready_i = 1'b0;
    endtask

    task automatic chk_counts(input string tag, input int unsigned b, input int unsigned m);
        chk({tag, "_bch"}, 32'(bch_a), b);
        chk({tag, "_mis"}, 32'(mis_a), m);
    endtask

    initial begin
        rst = 1'b1;
        id_bch_valid_i = 1'b0; id_bch_prediction_i = 1'b0; id_bch_target_i = '0;
        id_pc_i = '0; id_is_compressed_i = 1'b0; ex_resolve_valid_i = 1'b0;
        ex_bch_taken_i = 1'b0; kill_i = 1'b0; redirect_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready_a), 32'd1);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_flush", 32'(flush_a), 32'd0);
        chk("rst_pc", pc_a, 32'd0);
        chk_counts("rst", 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Correctly predicted taken branch
        send_bch(1'b1, 32'h0000_0FF0, 32'h0000_1000, 1'b0);
        chk("pend_ready", 32'(ready_a), 32'd0);
        resolve(1'b1, 1'b0);
        chk("ok_valid", 32'(valid_a), 32'd0);
        chk("ok_ready", 32'(ready_a), 32'd1);
        chk_counts("ok", 1, 0);
        chk("w2_bch1", 32'(bch_b), 32'd1);

        // Predicted not-taken, actually taken: redirect to target at N+1
        send_bch(1'b0, 32'h0000_2000, 32'h0000_2040, 1'b0);
        chk("pend_valid", 32'(valid_a), 32'd0);
        resolve(1'b1, 1'b0);
        chk("mp_valid", 32'(valid_a), 32'd1);
        chk("mp_pc", pc_a, 32'h0000_2040);
        chk("mp_flush", 32'(flush_a), 32'd1);
        chk("mp_ready", 32'(ready_a), 32'd0);
        chk_counts("mp", 2, 1);
        accept_redirect();
        chk("mp_done_valid", 32'(valid_a), 32'd0);
        chk("mp_done_ready", 32'(ready_a), 32'd1);
        chk("mp_done_pc", pc_a, 32'd0);

        // Compressed, predicted taken, not taken; IF stalls three cycles
        send_bch(1'b1, 32'h0000_3002, 32'h0000_3100, 1'b1);
        resolve(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 32'(valid_a), 32'd1);
            chk("hold_pc", pc_a, 32'h0000_3004);
            @(negedge clk);
        end
        accept_redirect();
        chk("hold_done_valid", 32'(valid_a), 32'd0);
        chk("hold_done_ready", 32'(ready_a), 32'd1);
        chk_counts("hold", 3, 2);

        // Fallthrough wraps past the top of the address space
        send_bch(1'b1, 32'hFFFF_FFFC, 32'h0000_0100, 1'b0);
        resolve(1'b0, 1'b0);
        chk("wrap_valid", 32'(valid_a), 32'd1);
        chk("wrap_pc", pc_a, 32'h0000_0000);
        accept_redirect();
        chk_counts("wrap", 4, 3);

        // Kill on the resolving cycle discards the mispredict
        send_bch(1'b0, 32'h0000_5000, 32'h0000_5080, 1'b0);
        resolve(1'b1, 1'b1);
        chk("kill_valid", 32'(valid_a), 32'd0);
        chk("kill_ready", 32'(ready_a), 32'd1);
        chk_counts("kill", 4, 3);

        // Kill blocks a same-cycle ID hand-off
        id_bch_valid_i = 1'b1; kill_i = 1'b1;
        @(negedge clk);
        id_bch_valid_i = 1'b0; kill_i = 1'b0;
        chk("killid_ready", 32'(ready_a), 32'd1);

        // Resolution while idle is ignored
        resolve(1'b1, 1'b0);
        chk("idle_res_valid", 32'(valid_a), 32'd0);
        chk_counts("idle_res", 4, 3);

        // Kill during a pending redirect abandons it
        send_bch(1'b0, 32'h0000_6000, 32'h0000_6100, 1'b0);
        resolve(1'b1, 1'b0);
        chk("krd_valid", 32'(valid_a), 32'd1);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        chk("krd_valid_after", 32'(valid_a), 32'd0);
        chk("krd_ready_after", 32'(ready_a), 32'd1);
        chk_counts("krd", 5, 4);

        // Fifth mispredict: 2-bit counters stay saturated at 3
        send_bch(1'b1, 32'h0000_7000, 32'h0000_7100, 1'b0);
        resolve(1'b0, 1'b0);
        chk("last_valid", 32'(valid_a), 32'd1);
        chk("last_pc", pc_a, 32'h0000_7004);
        chk_counts("last", 6, 5);
        chk("w2_bch_sat", 32'(bch_b), 32'd3);
        chk("w2_mis_sat", 32'(mis_b), 32'd3);

        // Asynchronous reset while the redirect is still outstanding
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(valid_a), 32'd0);
        chk("arst_flush", 32'(flush_a), 32'd0);
        chk("arst_pc", pc_a, 32'd0);
        chk("arst_ready", 32'(ready_a), 32'd1);
        chk_counts("arst", 0, 0);
        chk("arst_w2_mis", 32'(mis_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
